// File: rtl/pwm_pkg.sv
// Shared FSM state encoding and default widths for the PWM burst controller.
// Widths: 32-bit timing words, 16-bit burst/cycle counters, 0xFFFF watchdog limit.
package pwm_pkg;

    localparam int unsigned DEF_RAM_WIDTH = 32;
    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam logic [31:0] DEF_TIMEOUT   = 32'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } pwm_state_t;

endpackage

// File: rtl/pwm_burst_ctrl_if.sv
// Bundle between the burst controller, its configuration source and the half-bridge stage.
// master = controller side, slave = configuration/half-bridge side.
interface pwm_burst_ctrl_if
    import pwm_pkg::*;
#(
    parameter int unsigned RW = DEF_RAM_WIDTH,
    parameter int unsigned CW = DEF_CNT_WIDTH
);

    logic          start;
    logic          pwm_dis;
    logic [RW-1:0] cfg_die_period;
    logic [RW-1:0] cfg_pulse_period;
    logic [RW-1:0] cfg_gap;
    logic [CW-1:0] cfg_burst_num;
    logic          half_done;

    logic [RW-1:0] die_period;
    logic [RW-1:0] pulse_period;
    logic          half_en;
    logic          busy;
    logic          burst_done;
    logic [CW-1:0] cyc_cnt;
    logic          timeout_err;

    modport master (
        input  start, pwm_dis, cfg_die_period, cfg_pulse_period, cfg_gap,
               cfg_burst_num, half_done,
        output die_period, pulse_period, half_en, busy, burst_done, cyc_cnt,
               timeout_err
    );

    modport slave (
        output start, pwm_dis, cfg_die_period, cfg_pulse_period, cfg_gap,
               cfg_burst_num, half_done,
        input  die_period, pulse_period, half_en, busy, burst_done, cyc_cnt,
               timeout_err
    );

endinterface

// File: rtl/pwm_gap_timer.sv
// Loadable down-counter; expire_o strobes in the last enabled clock of a loaded interval.
// Load has priority over counting; a loaded value N gives expire on the Nth enabled clock.
module pwm_gap_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/pwm_burst_ctrl.sv
// Burst sequencer firing N half-bridge cycles with optional idle gaps; half_en one clock after start.
// No backpressure: half_done paces the burst; WAIT watchdog only when PWM_BURST_TIMEOUT_EN is defined.
module pwm_burst_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned _RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int unsigned _CNT_WIDTH = DEF_CNT_WIDTH,
    parameter logic [31:0] _TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             io_clk,
    input  logic             io_rst,
    pwm_burst_ctrl_if.master bus
);

    pwm_state_t              state_q;
    logic                    half_en_q;
    logic                    busy_q;
    logic                    burst_done_q;
    logic [_CNT_WIDTH-1:0]   cyc_cnt_q;
    logic [_CNT_WIDTH-1:0]   burst_num_q;
    logic [_RAM_WIDTH-1:0]   gap_q;
    logic [_RAM_WIDTH-1:0]   die_q;
    logic [_RAM_WIDTH-1:0]   pulse_q;
    logic [_CNT_WIDTH-1:0]   cyc_inc;
    logic                    gap_expire;

    assign cyc_inc = cyc_cnt_q + 1'b1;

    // Reloaded every WAIT clock so GAP always starts from the shadow value.
    pwm_gap_timer #(.W(_RAM_WIDTH)) u_gap (
        .clk_i      (io_clk),
        .rst_i      (io_rst),
        .load_i     (state_q == ST_WAIT),
        .load_val_i (gap_q),
        .en_i       (state_q == ST_GAP),
        .expire_o   (gap_expire)
    );

`ifdef PWM_BURST_TIMEOUT_EN
    logic wd_expire;
    logic timeout_err_q;

    pwm_gap_timer #(.W(32)) u_wd (
        .clk_i      (io_clk),
        .rst_i      (io_rst),
        .load_i     (state_q != ST_WAIT),
        .load_val_i (_TIMEOUT),
        .en_i       (state_q == ST_WAIT),
        .expire_o   (wd_expire)
    );

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout  = ^_TIMEOUT;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q      <= ST_IDLE;
            half_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            cyc_cnt_q    <= '0;
            burst_num_q  <= '0;
            gap_q        <= '0;
            die_q        <= '0;
            pulse_q      <= '0;
`ifdef PWM_BURST_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            half_en_q    <= 1'b0;
            burst_done_q <= 1'b0;
            if (bus.pwm_dis) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.start && (bus.cfg_burst_num != '0)) begin
                            burst_num_q <= bus.cfg_burst_num;
                            gap_q       <= bus.cfg_gap;
                            die_q       <= bus.cfg_die_period;
                            pulse_q     <= bus.cfg_pulse_period;
                            cyc_cnt_q   <= '0;
                            state_q     <= ST_FIRE;
                            half_en_q   <= 1'b1;
                            busy_q      <= 1'b1;
`ifdef PWM_BURST_TIMEOUT_EN
                            timeout_err_q <= 1'b0;
`endif
                        end
                    end
                    ST_FIRE: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (bus.half_done) begin
                            cyc_cnt_q <= cyc_inc;
                            if (cyc_inc == burst_num_q) begin
                                state_q      <= ST_DONE;
                                burst_done_q <= 1'b1;
                            end else if (gap_q == '0) begin
                                state_q   <= ST_FIRE;
                                half_en_q <= 1'b1;
                            end else begin
                                state_q <= ST_GAP;
                            end
                        end
`ifdef PWM_BURST_TIMEOUT_EN
                        else if (wd_expire) begin
                            state_q       <= ST_IDLE;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                        end
`endif
                    end
                    ST_GAP: begin
                        if (gap_expire) begin
                            state_q   <= ST_FIRE;
                            half_en_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.die_period   = die_q;
    assign bus.pulse_period = pulse_q;
    assign bus.half_en      = half_en_q;
    assign bus.busy         = busy_q;
    assign bus.burst_done   = burst_done_q;
    assign bus.cyc_cnt      = cyc_cnt_q;

endmodule

// File: tb/tb_pwm_burst_ctrl.sv
// Scoreboard bench: bursts are predicted from cycle arithmetic; a negedge monitor pops and compares.
// Watchdog scenario switches on PWM_BURST_TIMEOUT_EN.
module tb_pwm_burst_ctrl;
    import pwm_pkg::*;

    typedef struct {
        int          kind;   // 0 = half_en, 1 = burst_done
        int          cyc;
        int          cnt;
        logic [31:0] die;
        logic [31:0] pulse;
    } ev_t;

    typedef struct {
        int     cyc;
        string  name;
        int     sel;
        longint val;
    } pt_t;

    ev_t exp_q[$];
    pt_t pt_q[$];
    ev_t mon_e;
    pt_t mon_p;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  hd_at = -1;
    int  hd_dly = 3;
    bit  spur = 0;
    bit  respond = 1;
    int  busy_lo = 0;
    int  busy_hi = -1;
    bit  fin_req = 0;
    bit  fin_done = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_burst_ctrl_if #(.RW(32), .CW(16)) bif ();

    pwm_burst_ctrl #(
        ._RAM_WIDTH (32),
        ._CNT_WIDTH (16),
        ._TIMEOUT   (32'd16)
    ) dut (
        .io_clk (clk),
        .io_rst (rst),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    // Cycle counter and half-bridge model: half_done hd_dly clocks after each half_en,
    // optionally followed by a spurious strobe that the DUT must ignore.
    initial begin
        bif.half_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bif.half_done = respond && ((cyc == hd_at) || (spur && (cyc == hd_at + 1)));
        end
    end

    always @(negedge clk) begin
        if (rst) hd_at = -1;
        else if (bif.half_en === 1'b1) hd_at = cyc + hd_dly;
    end

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic longint sig(int sel);
        case (sel)
            0: return longint'(bif.busy);
            1: return longint'(bif.cyc_cnt);
            2: return longint'(bif.timeout_err);
            3: return longint'(bif.die_period);
            4: return longint'(bif.pulse_period);
            5: return longint'(bif.half_en);
            default: return longint'(bif.burst_done);
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("busy", longint'(bif.busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                chk("missed_event_cycle", cyc, mon_e.cyc);
            end
            if (bif.half_en === 1'b1 || bif.burst_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("event_kind", (bif.half_en === 1'b1) ? 0 : 1, mon_e.kind);
                    chk("event_cyc_cnt", longint'(bif.cyc_cnt), mon_e.cnt);
                    chk("event_die_period", longint'(bif.die_period), longint'(mon_e.die));
                    chk("event_pulse_period", longint'(bif.pulse_period), longint'(mon_e.pulse));
                end
            end
            while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
                mon_p = pt_q.pop_front();
                if (mon_p.cyc < cyc) chk({"missed_", mon_p.name}, cyc, mon_p.cyc);
                else chk(mon_p.name, sig(mon_p.sel), mon_p.val);
            end
            if (fin_req && !fin_done) begin
                chk("events_left", exp_q.size(), 0);
                chk("points_left", pt_q.size(), 0);
                fin_done = 1;
            end
        end
    end

    function automatic void push_ev(int kind, int c, int cnt, logic [31:0] die, logic [31:0] pulse);
        ev_t e;
        e = '{kind, c, cnt, die, pulse};
        exp_q.push_back(e);
    endfunction

    function automatic void push_pt(int c, string nm, int sel, longint v);
        pt_t p;
        int  i;
        p = '{c, nm, sel, v};
        i = 0;
        while (i < pt_q.size() && pt_q[i].cyc <= c) i++;
        pt_q.insert(i, p);
    endfunction

    task automatic at_cycle(int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Predicts a whole burst: half_en one clock after start, half_done d clocks after each
    // half_en, next half_en 1+gap clocks after half_done, burst_done one clock after the last.
    task automatic run_burst(input int nb, input int gap, input int d,
                             input logic [31:0] die, input logic [31:0] pulse,
                             input bit mid, input logic [31:0] mid_pulse);
        int n, h, k;
        bif.cfg_burst_num    = 16'(nb);
        bif.cfg_gap          = 32'(gap);
        bif.cfg_die_period   = die;
        bif.cfg_pulse_period = pulse;
        hd_dly = d;
        spur   = 1'($urandom_range(0, 1));
        n = cyc;
        bif.start = 1'b1;
        h = n + 1;
        k = h;
        for (int i = 1; i <= nb; i++) begin
            push_ev(0, h, i - 1, die, pulse);
            k = h + d;
            if (i < nb) h = k + 1 + gap;
        end
        push_ev(1, k + 1, nb, die, pulse);
        busy_lo = n + 1;
        busy_hi = k + 1;
        push_pt(k + 2, "cyc_cnt_hold", 1, nb);
        push_pt(k + 2, "timeout_err_clear", 2, 0);
        push_pt(k + 2, "pulse_period_hold", 4, longint'(pulse));
        at_cycle(n + 1);
        bif.start = 1'b0;
        if (mid) begin
            at_cycle(n + 2);
            bif.cfg_pulse_period = mid_pulse;
            bif.cfg_die_period   = $urandom;
            bif.cfg_gap          = 32'($urandom_range(0, 5));
            bif.cfg_burst_num    = 16'($urandom_range(1, 5));
            bif.start = 1'b1;
            at_cycle(n + 3);
            bif.start = 1'b0;
        end
        at_cycle(k + 3);
    endtask

    initial begin
        int n, h1, h2, gap;
        bif.start            = 1'b0;
        bif.pwm_dis          = 1'b0;
        bif.cfg_die_period   = '0;
        bif.cfg_pulse_period = '0;
        bif.cfg_gap          = '0;
        bif.cfg_burst_num    = '0;

        for (int s = 0; s <= 6; s++) push_pt(2, "reset_value", s, 0);
        at_cycle(3);
        rst = 1'b0;
        at_cycle(5);

        // Three back-to-back cycles, then a mid-burst pulse width change that must wait.
        run_burst(3, 0, 5, 32'd7, 32'd20, 1'b1, 32'd50);
        run_burst(2, 4, $urandom_range(1, 6), 32'd9, 32'd50, 1'b0, 32'd0);

        for (int b = 0; b < 6; b++) begin
            run_burst($urandom_range(1, 5), $urandom_range(0, 5), $urandom_range(1, 6),
                      $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end

        // Abort in WAIT after the first completed cycle of four.
        gap = $urandom_range(0, 3);
        bif.cfg_burst_num    = 16'd4;
        bif.cfg_gap          = 32'(gap);
        bif.cfg_die_period   = 32'd3;
        bif.cfg_pulse_period = 32'd11;
        hd_dly = 3;
        spur   = 1'b0;
        n  = cyc;
        h1 = n + 1;
        h2 = h1 + 3 + 1 + gap;
        bif.start = 1'b1;
        push_ev(0, h1, 0, 32'd3, 32'd11);
        push_ev(0, h2, 1, 32'd3, 32'd11);
        busy_lo = n + 1;
        busy_hi = h2 + 1;
        push_pt(h2 + 3, "abort_cyc_cnt", 1, 1);
        push_pt(h2 + 3, "abort_timeout_err", 2, 0);
        at_cycle(n + 1);
        bif.start = 1'b0;
        at_cycle(h2 + 1);
        bif.pwm_dis = 1'b1;
        at_cycle(h2 + 2);
        bif.pwm_dis = 1'b0;
        at_cycle(h2 + 6);

        // Zero-length burst request is ignored and leaves cyc_cnt alone.
        bif.cfg_burst_num = '0;
        n = cyc;
        bif.start = 1'b1;
        push_pt(n + 3, "zero_burst_cyc_cnt", 1, 1);
        at_cycle(n + 1);
        bif.start = 1'b0;
        at_cycle(n + 5);

        // half_done withheld.
        respond = 1'b0;
        bif.cfg_burst_num = 16'd1;
        bif.cfg_gap       = '0;
        n = cyc;
        bif.start = 1'b1;
        push_ev(0, n + 1, 0, bif.cfg_die_period, bif.cfg_pulse_period);
`ifdef PWM_BURST_TIMEOUT_EN
        busy_lo = n + 1;
        busy_hi = n + 17;
        push_pt(n + 17, "timeout_err_pre", 2, 0);
        push_pt(n + 18, "timeout_err_set", 2, 1);
        push_pt(n + 25, "timeout_err_sticky", 2, 1);
        at_cycle(n + 1);
        bif.start = 1'b0;
        at_cycle(n + 26);
        respond = 1'b1;
        run_burst(1, 0, 2, 32'd5, 32'd6, 1'b0, 32'd0);
`else
        busy_lo = n + 1;
        busy_hi = n + 40;
        push_pt(n + 30, "no_watchdog_timeout_err", 2, 0);
        at_cycle(n + 1);
        bif.start = 1'b0;
        at_cycle(n + 40);
        bif.pwm_dis = 1'b1;
        at_cycle(n + 41);
        bif.pwm_dis = 1'b0;
        at_cycle(n + 44);
        respond = 1'b1;
`endif

        // Reset mid-burst: the second half_en must never appear.
        bif.cfg_burst_num    = 16'd3;
        bif.cfg_gap          = 32'd2;
        bif.cfg_die_period   = 32'd13;
        bif.cfg_pulse_period = 32'd17;
        hd_dly = 4;
        spur   = 1'b0;
        n = cyc;
        bif.start = 1'b1;
        push_ev(0, n + 1, 0, 32'd13, 32'd17);
        busy_lo = n + 1;
        busy_hi = n + 2;
        at_cycle(n + 1);
        bif.start = 1'b0;
        at_cycle(n + 3);
        rst = 1'b1;
        push_pt(n + 4, "rst_die_period", 3, 0);
        push_pt(n + 4, "rst_pulse_period", 4, 0);
        push_pt(n + 4, "rst_cyc_cnt", 1, 0);
        at_cycle(n + 5);
        rst = 1'b0;
        at_cycle(n + 14);

        run_burst(2, 1, 2, 32'd21, 32'd22, 1'b0, 32'd0);

        fin_req = 1;
        for (int w = 0; w < 10 && !fin_done; w++) @(negedge clk);
        #1;
        if (!fin_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL final_check: monitor did not complete, got 0 expected 1");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
